// File: rtl/param_lifo_stack.sv
// param_lifo_stack: parametrised push-down (LIFO) stack.
//
// Push and pop have separate strobes. Asserting both at once replaces the
// top entry and returns the old top. Popped data is registered on data_o,
// with a one-cycle valid_o pulse. The stack also reports a live occupancy
// count, empty/full/almost_full flags and sticky overflow/underflow flags.
//
// Ports:
//   Clk          in   clock, rising edge
//   Rst          in   asynchronous active-high reset
//   push_i       in   push request
//   pop_i        in   pop request
//   clr_err_i    in   synchronous clear of overflow/underflow
//   data_i       in   [DATAWIDTH]   data to push
//   data_o       out  [DATAWIDTH]   last popped value, held between pops
//   valid_o      out  data_o updated this cycle
//   count_o      out  [ADDRWIDTH+1] stored entries, 0..DEPTH
//   empty        out  count_o == 0
//   full         out  count_o == DEPTH
//   almost_full  out  count_o >= AFULL_LEVEL
//   overflow     out  sticky: push rejected while full
//   underflow    out  sticky: pop rejected while empty
module param_lifo_stack #(
  parameter int DATAWIDTH   = 8,
  parameter int ADDRWIDTH   = 10,
  parameter int AFULL_LEVEL = 2**ADDRWIDTH - 4
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic                 clr_err_i,
  input  logic [DATAWIDTH-1:0] data_i,
  output logic [DATAWIDTH-1:0] data_o,
  output logic                 valid_o,
  output logic [ADDRWIDTH:0]   count_o,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_full,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int DEPTH = 2**ADDRWIDTH;
  localparam logic [ADDRWIDTH:0] DEPTH_CNT = DEPTH[ADDRWIDTH:0];
  localparam logic [ADDRWIDTH:0] AFULL_CNT = AFULL_LEVEL[ADDRWIDTH:0];

  logic [DATAWIDTH-1:0] mem [DEPTH];

  logic [ADDRWIDTH-1:0] top_addr;
  logic [ADDRWIDTH-1:0] wr_addr;
  logic                 push_ok;
  logic                 pop_ok;
  logic                 replace;
  logic                 push_rej;
  logic                 pop_rej;

  assign empty       = (count_o == '0);
  assign full        = (count_o == DEPTH_CNT);
  assign almost_full = (count_o >= AFULL_CNT);

  // When the stack is full the low address bits wrap to zero, so
  // subtracting one still lands on DEPTH-1.
  assign top_addr = count_o[ADDRWIDTH-1:0] - 1'b1;

  // A push is only refused when it is alone and the stack is full.
  // Replace-top on a full stack is legal and leaves the count unchanged.
  assign push_ok  = push_i & (pop_i | ~full);
  assign pop_ok   = pop_i & ~empty;
  assign replace  = push_i & pop_i & ~empty;
  assign push_rej = push_i & ~pop_i & full;
  assign pop_rej  = pop_i & empty;
  assign wr_addr  = replace ? top_addr : count_o[ADDRWIDTH-1:0];

  // The storage array is not reset. A write sampled while Rst is high is
  // dropped so that the array stays consistent with the cleared count.
  always_ff @(posedge Clk) begin
    if (!Rst && push_ok) begin
      mem[wr_addr] <= data_i;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      count_o   <= '0;
      data_o    <= '0;
      valid_o   <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      valid_o <= pop_ok;
      if (pop_ok) begin
        data_o <= mem[top_addr];
      end

      if (push_ok && !pop_ok) begin
        count_o <= count_o + 1'b1;
      end else if (pop_ok && !push_ok) begin
        count_o <= count_o - 1'b1;
      end

      // A new rejection takes priority over a clear in the same cycle.
      overflow  <= push_rej | (overflow  & ~clr_err_i);
      underflow <= pop_rej  | (underflow & ~clr_err_i);
    end
  end

endmodule
